mem_request_fsm: RTL

MEM_REQUEST_FSM -- requirements
Module: mem_request_fsm

---
 rtl/mem_request_fsm.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mem_request_fsm.sv
// Pipeline-less CPU memory sequencer: fetches an instruction, optionally performs
// one data access, advances the PC, and traps on halt or a stalled memory system.
module mem_request_fsm #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 255
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic              halt,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  input  logic              ihit,
  input  logic              dhit,
  input  logic [DATA_W-1:0] dmemload,
  output logic              imemREN,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [ADDR_W-1:0] dmemaddr,
  output logic [DATA_W-1:0] dmemstore,
  output logic [DATA_W-1:0] dload,
  output logic              pc_en,
  output logic              halt_out,
  output logic              err,
  output logic [15:0]       wait_cnt
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DATA   = 2'd1,
    HALTED = 2'd2,
    ERROR  = 2'd3
  } state_t;

  localparam logic [15:0] max_wait_c = 16'(MAX_WAIT);

  state_t      state;
  logic        in_fetch;
  logic        in_data;
  logic        wd_trip;
  logic        mem_op;
  logic [15:0] cnt_inc;

  assign in_fetch = (state == FETCH);
  assign in_data  = (state == DATA);
  assign mem_op   = dREN | dWEN;

  // The watchdog outranks a late hit, so the strobe is masked on the tripping cycle.
  assign wd_trip  = (wait_cnt >= max_wait_c);

  // Saturating increment; MAX_WAIT normally trips first, this only guards the 16-bit range.
  assign cnt_inc  = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;

  // imemREN and pc_en are state decodes qualified by the live handshake inputs,
  // which is what gives the zero-extra-cycle PC advance on a plain ALU op.
  assign imemREN = in_fetch & iREN;
  assign pc_en   = ~RST & ~wd_trip &
                   ((in_fetch & ihit & ~halt & ~mem_op) | (in_data & dhit));

  // NOTE: every register here, including the wide data registers, uses non-blocking
  // assignment and is cleared by the asynchronous reset so dmemREN/dmemWEN drop
  // immediately when RST rises, without waiting for a clock edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= FETCH;
      wait_cnt  <= '0;
      dmemaddr  <= '0;
      dmemstore <= '0;
      dload     <= '0;
      dmemREN   <= 1'b0;
      dmemWEN   <= 1'b0;
      halt_out  <= 1'b0;
      err       <= 1'b0;
    end else begin
      unique case (state)
        FETCH: begin
          if (wd_trip) begin
            state    <= ERROR;
            err      <= 1'b1;
            wait_cnt <= '0;
          end else if (ihit) begin
            wait_cnt <= '0;
            if (halt) begin
              state    <= HALTED;
              halt_out <= 1'b1;
            end else if (mem_op) begin
              state     <= DATA;
              dmemaddr  <= daddr;
              dmemstore <= dstore;
              // A store wins when the decoder flags both directions.
              dmemWEN   <= dWEN;
              dmemREN   <= ~dWEN;
            end
          end else if (iREN) begin
            wait_cnt <= cnt_inc;
          end
        end

        DATA: begin
          if (wd_trip) begin
            state    <= ERROR;
            err      <= 1'b1;
            dmemREN  <= 1'b0;
            dmemWEN  <= 1'b0;
            wait_cnt <= '0;
          end else if (dhit) begin
            state    <= FETCH;
            wait_cnt <= '0;
            dmemREN  <= 1'b0;
            dmemWEN  <= 1'b0;
            if (dmemREN) dload <= dmemload;
          end else begin
            wait_cnt <= cnt_inc;
          end
        end

        HALTED: ;

        ERROR: ;

        default: begin
          state    <= ERROR;
          err      <= 1'b1;
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule
